// File: rtl/ads8528_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ads8528_ctrl
// Description : Parallel-bus controller for an 8-channel simultaneous-sampling
//               ADC: writes the config word, converts, reads 8 samples.
// Revision    : 1.0 - initial release
// ============================================================================
module ads8528_ctrl #(
    parameter logic [31:0] CFG_DEFAULT = 32'h0000_03FF,
    parameter int          T_PULSE     = 3,
    parameter int          T_GAP       = 2,
    parameter int          BUSY_TMO    = 1023
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        cfg_load,
    input  logic [31:0] cfg_word,
    input  logic        BUSY,
    input  logic [15:0] DB_IN,
    output logic [15:0] DB_OUT,
    output logic        DB_OE,
    output logic        CS_N,
    output logic        WR_N,
    output logic        RD_N,
    output logic [3:0]  CONVST,
    output logic [15:0] smp_data,
    output logic [2:0]  smp_ch,
    output logic        smp_valid,
    input  logic        smp_ready,
    output logic        err_tmo,
    output logic        err_ovr,
    output logic        ready
);

    localparam int               CNT_W        = 16;
    localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST   = CNT_W'(BUSY_TMO);

    localparam logic [2:0] S_CFG_HI  = 3'd0;
    localparam logic [2:0] S_CFG_LO  = 3'd1;
    localparam logic [2:0] S_IDLE    = 3'd2;
    localparam logic [2:0] S_CONV    = 3'd3;
    localparam logic [2:0] S_WAIT_BH = 3'd4;
    localparam logic [2:0] S_WAIT_BL = 3'd5;
    localparam logic [2:0] S_READ    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gap_q, gap_d;
    logic             run_q, run_d;
    logic             fin_q, fin_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       busy_sync_q, busy_sync_d;
    logic [15:0]      smp_data_q, smp_data_d;
    logic [2:0]       smp_ch_q, smp_ch_d;
    logic             smp_valid_q, smp_valid_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_ovr_q, err_ovr_d;

    logic             w_busy;
    logic             w_hold;

    assign w_busy = busy_sync_q[1];
    assign w_hold = smp_valid_q & ~smp_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_CFG_HI;
            cnt_q       <= '0;
            gap_q       <= 1'b0;
            run_q       <= 1'b0;
            fin_q       <= 1'b0;
            idx_q       <= 3'd0;
            word_q      <= CFG_DEFAULT;
            busy_sync_q <= 2'b00;
            smp_data_q  <= 16'h0000;
            smp_ch_q    <= 3'd0;
            smp_valid_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            run_q       <= run_d;
            fin_q       <= fin_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            busy_sync_q <= busy_sync_d;
            smp_data_q  <= smp_data_d;
            smp_ch_q    <= smp_ch_d;
            smp_valid_q <= smp_valid_d;
            err_tmo_q   <= err_tmo_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    // run_q keeps the bus quiet for the first cycle out of reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        run_d       = 1'b1;
        fin_d       = fin_q;
        idx_d       = idx_q;
        word_d      = word_q;
        busy_sync_d = {busy_sync_q[0], BUSY};
        smp_data_d  = smp_data_q;
        smp_ch_d    = smp_ch_q;
        smp_valid_d = w_hold;
        err_tmo_d   = 1'b0;
        err_ovr_d   = (start | cfg_load) & (state_q != S_IDLE);
        case (state_q)
            S_CFG_HI, S_CFG_LO: begin
                if (run_q) begin
                    if (!gap_q) begin
                        if (cnt_q == C_PULSE_LAST) begin
                            gap_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + C_ONE;
                        end
                    end else if (cnt_q == C_GAP_LAST) begin
                        gap_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = (state_q == S_CFG_HI) ? S_CFG_LO : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end
            end
            S_IDLE: begin
                if (cfg_load) begin
                    word_d    = cfg_word;
                    state_d   = S_CFG_HI;
                    cnt_d     = '0;
                    gap_d     = 1'b0;
                    err_ovr_d = start;
                end else if (start) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end
            end
            S_CONV: begin
                if (cnt_q == C_PULSE_LAST) begin
                    state_d = S_WAIT_BH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_WAIT_BH, S_WAIT_BL: begin
                if (w_busy == (state_q == S_WAIT_BH)) begin
                    cnt_d = '0;
                    if (state_q == S_WAIT_BH) begin
                        state_d = S_WAIT_BL;
                    end else begin
                        // Enter with the gap already elapsed; first pulse waits only for a free output register.
                        state_d = S_READ;
                        cnt_d   = C_GAP_LAST;
                        gap_d   = 1'b1;
                        fin_d   = 1'b0;
                    end
                end else if (cnt_q == C_TMO_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    err_tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_READ: begin
                if (!gap_q) begin
                    if (cnt_q == C_PULSE_LAST) begin
                        smp_data_d  = DB_IN;
                        smp_ch_d    = idx_q;
                        smp_valid_d = 1'b1;
                        idx_d       = idx_q + 3'd1;
                        fin_d       = (idx_q == 3'd7);
                        gap_d       = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + C_ONE;
                    end
                end else if (cnt_q != C_GAP_LAST) begin
                    cnt_d = cnt_q + C_ONE;
                end else if (fin_q) begin
                    state_d = S_IDLE;
                    gap_d   = 1'b0;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                end else if (!w_hold) begin
                    gap_d = 1'b0;
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                gap_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        CS_N   = 1'b1;
        WR_N   = 1'b1;
        RD_N   = 1'b1;
        DB_OE  = 1'b0;
        DB_OUT = 16'h0000;
        CONVST = 4'h0;
        case (state_q)
            S_CFG_HI, S_CFG_LO: begin
                if (run_q) begin
                    CS_N   = 1'b0;
                    DB_OE  = 1'b1;
                    WR_N   = gap_q;
                    DB_OUT = (state_q == S_CFG_HI) ? word_q[31:16] : word_q[15:0];
                end
            end
            S_CONV: CONVST = 4'hF;
            S_READ: begin
                CS_N = 1'b0;
                RD_N = gap_q;
            end
            default: ;
        endcase
    end

    assign ready     = (state_q == S_IDLE);
    assign smp_data  = smp_data_q;
    assign smp_ch    = smp_ch_q;
    assign smp_valid = smp_valid_q;
    assign err_tmo   = err_tmo_q;
    assign err_ovr   = err_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_ads8528_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ads8528_ctrl
// Description : Directed self-checking bench for ads8528_ctrl with a small
//               ADC model returning 16'h1000 + read index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ads8528_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        cfg_load = 1'b0;
    logic [31:0] cfg_word = 32'h0;
    logic        BUSY = 1'b0;
    logic [15:0] DB_IN = 16'h0;
    logic        smp_ready = 1'b1;
    logic [15:0] DB_OUT;
    logic        DB_OE;
    logic        CS_N;
    logic        WR_N;
    logic        RD_N;
    logic [3:0]  CONVST;
    logic [15:0] smp_data;
    logic [2:0]  smp_ch;
    logic        smp_valid;
    logic        err_tmo;
    logic        err_ovr;
    logic        ready;

    ads8528_ctrl dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .cfg_load  (cfg_load),
        .cfg_word  (cfg_word),
        .BUSY      (BUSY),
        .DB_IN     (DB_IN),
        .DB_OUT    (DB_OUT),
        .DB_OE     (DB_OE),
        .CS_N      (CS_N),
        .WR_N      (WR_N),
        .RD_N      (RD_N),
        .CONVST    (CONVST),
        .smp_data  (smp_data),
        .smp_ch    (smp_ch),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .err_tmo   (err_tmo),
        .err_ovr   (err_ovr),
        .ready     (ready)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_idx   = 0;
    int          rd_falls = 0;
    int          viol    = 0;
    logic [18:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: data for read i is presented when RD_N falls.
    always @(negedge RD_N) begin
        DB_IN = 16'h1000 + 16'(m_idx);
        m_idx = (m_idx + 1) % 8;
        rd_falls++;
    end

    always @(negedge CLK) begin
        if (RST_N && smp_valid && smp_ready) got_q.push_back({smp_ch, smp_data});
        if ((!WR_N && !RD_N) || (DB_OE && CS_N)) viol++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic [15:0] exp_data);
        int k;
        int n;
        k = 0;
        @(negedge CLK);
        while (WR_N && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_wr"}, 32'(WR_N), 0);
        check({tag, "_data"}, 32'(DB_OUT), 32'(exp_data));
        check({tag, "_oe"}, 32'(DB_OE & ~CS_N), 1);
        n = 0;
        while (!WR_N && n < 20) begin
            n++;
            @(negedge CLK);
        end
        check({tag, "_len"}, n, 3);
    endtask

    task automatic run_frame(input string tag);
        int k;
        check({tag, "_rdy"}, 32'(ready), 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check({tag, "_conv"}, 32'(CONVST), 32'hF);
        k = 0;
        while (CONVST != 4'h0 && k < 50) begin
            cyc(1);
            k++;
        end
        check({tag, "_convlen"}, k, 3);
        cyc(2);
        BUSY = 1'b1;
        cyc(20);
        BUSY = 1'b0;
        k = 0;
        while (!ready && k < 3000) begin
            cyc(1);
            k++;
        end
        check({tag, "_done"}, 32'(ready), 1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_cnt"}, got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check($sformatf("%s_s%0d", tag, i), 32'(got_q[i]), 32'({3'(i), 16'h1000 + 16'(i)}));
        got_q.delete();
    endtask

    initial begin
        int k;
        int bad;
        int rd0;

        cyc(3);
        check("rst_cs", 32'(CS_N), 1);
        check("rst_strobes", 32'({WR_N, RD_N, CONVST}), 32'h30);
        check("rst_bus", 32'({DB_OE, DB_OUT}), 0);
        check("rst_out", 32'({smp_valid, smp_ch, err_tmo, err_ovr, ready}), 0);
        check("rst_data", 32'(smp_data), 0);

        RST_N = 1'b1;
        expect_write("cfg0_hi", 16'h0000);
        expect_write("cfg0_lo", 16'h03FF);
        k = 0;
        while (!ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("cfg0_ready_lat", k, 2);
        check("cfg0_cs_rel", 32'({CS_N, DB_OE}), 32'h2);
        cyc(1);

        run_frame("f1");
        check_frame("f1");

        cyc(2);
        fork
            run_frame("bp");
            begin
                k = 0;
                while (!(smp_valid && smp_ch == 3'd2) && k < 2000) begin
                    cyc(1);
                    k++;
                end
                smp_ready = 1'b0;
                bad = 0;
                repeat (50) begin
                    @(negedge CLK);
                    if (!RD_N || !smp_valid || smp_data != 16'h1002 || smp_ch != 3'd2) bad++;
                end
                check("bp_hold", bad, 0);
                cyc(1);
                smp_ready = 1'b1;
            end
        join
        check_frame("bp");

        cyc(2);
        rd0 = rd_falls;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        k = 0;
        while (CONVST != 4'h0 && k < 50) begin
            cyc(1);
            k++;
        end
        k = 0;
        while (!err_tmo && k < 1100) begin
            cyc(1);
            k++;
        end
        check("tmo_lat", k, 1024);
        check("tmo_ready", 32'(ready), 1);
        cyc(1);
        check("tmo_pulse", 32'(err_tmo), 0);
        check("tmo_no_rd", rd_falls - rd0, 0);

        cyc(2);
        fork
            run_frame("ovr");
            begin
                k = 0;
                while (RD_N && k < 2000) begin
                    cyc(1);
                    k++;
                end
                start = 1'b1;
                cyc(1);
                start = 1'b0;
                check("ovr_pulse", 32'(err_ovr), 1);
                cyc(1);
                check("ovr_clear", 32'(err_ovr), 0);
            end
        join
        check_frame("ovr");

        cyc(2);
        cfg_word = 32'hA5A5_5A5A;
        cfg_load = 1'b1;
        start    = 1'b1;
        cyc(1);
        cfg_load = 1'b0;
        start    = 1'b0;
        check("rcfg_ovr", 32'(err_ovr), 1);
        check("rcfg_noconv", 32'(CONVST), 0);
        expect_write("rcfg_hi", 16'hA5A5);
        expect_write("rcfg_lo", 16'h5A5A);
        k = 0;
        while (!ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("rcfg_ready", 32'(ready), 1);
        cyc(1);

        fork
            run_frame("rst");
            begin
                k = 0;
                while (got_q.size() < 5 && k < 2000) begin
                    cyc(1);
                    k++;
                end
                #2;
                RST_N = 1'b0;
                m_idx = 0;
                #1;
                check("mid_rst_cs", 32'({CS_N, RD_N, WR_N}), 32'h7);
                check("mid_rst_out", 32'({smp_valid, smp_ch, DB_OE, ready}), 0);
                check("mid_rst_data", 32'(smp_data), 0);
                cyc(2);
                RST_N = 1'b1;
                expect_write("rst_cfg_hi", 16'h0000);
                expect_write("rst_cfg_lo", 16'h03FF);
            end
        join
        got_q.delete();
        cyc(2);
        run_frame("post");
        check_frame("post");

        check("bus_exclusive", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
